// File: rtl/latch_wr_arbiter.sv
// latch_wr_arbiter: round-robin write-port controller for a shared D-latch bank.
// Each write runs setup / enable / hold so latch D is stable around its enable.
module latch_wr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int DW    = 8,
    parameter  int AW    = 2,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int NL    = 1 << AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic [AW-1:0]       lat_addr,
    output logic [DW-1:0]       lat_d,
    output logic [NL-1:0]       lat_en,
    output logic                busy,
    output logic [IW-1:0]       gnt_id
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD
    } state_t;

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [N_REQ-1:0] arb_req;
    logic             arb_hit;
    logic [IW-1:0]    arb_win;
    logic [IW-1:0]    next_ptr;
    logic [AW-1:0]    cap_addr;
    logic [DW-1:0]    cap_data;

    function automatic logic [IW-1:0] wrap_inc(
        input logic [IW-1:0] p,
        input int            k
    );
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    // The grantee leaving HOLD is masked so a pending peer always wins first.
    always_comb begin
        arb_req = req;
        if (state == HOLD) arb_req = req & ~(N_REQ'(1) << gnt_id);
        arb_hit = 1'b0;
        arb_win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!arb_hit && arb_req[wrap_inc(rr_ptr, i)]) begin
                arb_hit = 1'b1;
                arb_win = wrap_inc(rr_ptr, i);
            end
        end
    end

    assign next_ptr = wrap_inc(gnt_id, 1);
    assign cap_addr = req_addr[arb_win*AW +: AW];
    assign cap_data = req_data[arb_win*DW +: DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            ack      <= '0;
            lat_en   <= '0;
            lat_d    <= '0;
            lat_addr <= '0;
            busy     <= 1'b0;
            gnt_id   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_hit) begin
                        gnt_id   <= arb_win;
                        lat_addr <= cap_addr;
                        lat_d    <= cap_data;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    lat_en <= NL'(1) << lat_addr;
                    state  <= ENABLE;
                end
                ENABLE: begin
                    lat_en <= '0;
                    ack    <= N_REQ'(1) << gnt_id;
                    rr_ptr <= next_ptr;
                    state  <= HOLD;
                end
                HOLD: begin
                    ack <= '0;
                    if (arb_hit) begin
                        gnt_id   <= arb_win;
                        lat_addr <= cap_addr;
                        lat_d    <= cap_data;
                        state    <= SETUP;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// tb_latch_wr_arbiter: directed writes with a scoreboard of expected acks.
// A negedge monitor checks enable pulses and acks against the queue.
module tb_latch_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [1:0]  lat_addr;
    logic [7:0]  lat_d;
    logic [3:0]  lat_en;
    logic        busy;
    logic [1:0]  gnt_id;

    latch_wr_arbiter #(.N_REQ(4), .DW(8), .AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .lat_addr (lat_addr),
        .lat_d    (lat_d),
        .lat_en   (lat_en),
        .busy     (busy),
        .gnt_id   (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ack;
        logic [1:0] gnt;
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
        bit         abort;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          c;
    logic [3:0]  prev_en = '0;
    logic [9:0]  prev_ad = '0;
    logic [3:0]  one4 = 4'b0001;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, a, x);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic [1:0] a, input logic [7:0] d);
        req_addr[i*2 +: 2] = a;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic push(input logic [3:0] a, input logic [1:0] g, input logic [1:0] ad,
                        input logic [7:0] d, input int cy, input bit ab);
        exp_t x;
        x.ack = a;
        x.gnt = g;
        x.addr = ad;
        x.data = d;
        x.cyc = cy;
        x.abort = ab;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (lat_en != 0) begin
                if (sb.size() == 0) begin
                    chk("lat_en_unexpected", lat_en, 0);
                end else begin
                    e = sb[0];
                    chk("lat_en", lat_en, one4 << e.addr);
                    chk("en_lat_d", lat_d, e.data);
                    chk("en_cyc", cyc, e.cyc - 1);
                    chk("en_d_setup", {lat_addr, lat_d}, prev_ad);
                    if (e.abort) void'(sb.pop_front());
                end
            end
            if (prev_en != 0) chk("en_d_hold", {lat_addr, lat_d}, prev_ad);
            if (ack != 0) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", ack, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack", ack, e.ack);
                    chk("ack_gnt_id", gnt_id, e.gnt);
                    chk("ack_lat_d", lat_d, e.data);
                    chk("ack_lat_addr", lat_addr, e.addr);
                    chk("ack_cyc", cyc, e.cyc);
                end
            end
        end
        prev_en = lat_en;
        prev_ad = {lat_addr, lat_d};
    end

    initial begin
        tick(2);
        chk("rst_ack", ack, 0);
        chk("rst_lat_en", lat_en, 0);
        chk("rst_lat_d", lat_d, 0);
        chk("rst_lat_addr", lat_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        reset = 1'b0;
        tick(2);

        // single write from requester 2
        set_rq(2, 2'd1, 8'hA5);
        req = 4'b0100;
        c = cyc;
        push(4'b0100, 2'd2, 2'd1, 8'hA5, c + 3, 1'b0);
        tick(1);
        chk("setup_lat_d", lat_d, 8'hA5);
        chk("setup_lat_addr", lat_addr, 1);
        chk("setup_lat_en", lat_en, 0);
        chk("setup_busy", busy, 1);
        tick(1);
        chk("enable_lat_en", lat_en, 4'b0010);
        tick(1);
        chk("hold_gnt_id", gnt_id, 2);
        chk("hold_lat_en", lat_en, 0);
        req = 4'b0000;
        tick(1);
        chk("single_busy_fall", busy, 0);
        tick(2);

        // async reset while ENABLE is active
        set_rq(1, 2'd3, 8'h77);
        req = 4'b0010;
        c = cyc;
        push(4'b0010, 2'd1, 2'd3, 8'h77, c + 3, 1'b1);
        tick(2);
        #6;
        reset = 1'b1;
        req = 4'b0000;
        #1;
        chk("async_lat_en", lat_en, 0);
        chk("async_ack", ack, 0);
        chk("async_busy", busy, 0);
        chk("async_lat_d", lat_d, 0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // pointer is 0 after reset, so requester 0 beats 3
        set_rq(0, 2'd0, 8'h11);
        set_rq(3, 2'd2, 8'h33);
        req = 4'b1001;
        c = cyc;
        push(4'b0001, 2'd0, 2'd0, 8'h11, c + 3, 1'b0);
        push(4'b1000, 2'd3, 2'd2, 8'h33, c + 6, 1'b0);
        tick(3);
        req[0] = 1'b0;
        tick(3);
        req[3] = 1'b0;
        tick(1);
        chk("rst_pair_busy", busy, 0);
        tick(1);

        // lone requester 3
        set_rq(3, 2'd1, 8'h5A);
        req = 4'b1000;
        c = cyc;
        push(4'b1000, 2'd3, 2'd1, 8'h5A, c + 3, 1'b0);
        tick(3);
        req = 4'b0000;
        tick(3);

        // all four from reset
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) set_rq(i, 2'(i), 8'hC0 + 8'(i));
        req = 4'b1111;
        c = cyc;
        for (int i = 0; i < 4; i++)
            push(one4 << i, 2'(i), 2'(i), 8'hC0 + 8'(i), c + 3 + 3 * i, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(3);
            req[i] = 1'b0;
        end
        tick(1);
        chk("all4_busy", busy, 0);
        tick(1);

        // fairness between 0 and 1
        set_rq(0, 2'd2, 8'h01);
        set_rq(1, 2'd3, 8'h02);
        req = 4'b0011;
        c = cyc;
        push(4'b0001, 2'd0, 2'd2, 8'h01, c + 3, 1'b0);
        push(4'b0010, 2'd1, 2'd3, 8'h02, c + 6, 1'b0);
        push(4'b0001, 2'd0, 2'd2, 8'h01, c + 9, 1'b0);
        push(4'b0010, 2'd1, 2'd3, 8'h02, c + 12, 1'b0);
        tick(12);
        req = 4'b0000;
        tick(1);
        chk("fair_busy", busy, 0);
        tick(1);

        // sole requester keeps req high: IDLE inserted
        set_rq(1, 2'd0, 8'h9C);
        req = 4'b0010;
        c = cyc;
        push(4'b0010, 2'd1, 2'd0, 8'h9C, c + 3, 1'b0);
        push(4'b0010, 2'd1, 2'd0, 8'h9C, c + 7, 1'b0);
        push(4'b0010, 2'd1, 2'd0, 8'h9C, c + 11, 1'b0);
        tick(4);
        chk("rereq_idle_busy", busy, 0);
        tick(7);
        req = 4'b0000;
        tick(1);
        chk("rereq_busy", busy, 0);
        tick(1);

        // data change after capture is ignored
        set_rq(1, 2'd2, 8'h3C);
        req = 4'b0010;
        c = cyc;
        push(4'b0010, 2'd1, 2'd2, 8'h3C, c + 3, 1'b0);
        tick(1);
        set_rq(1, 2'd0, 8'hFF);
        tick(1);
        chk("capture_lat_d", lat_d, 8'h3C);
        chk("capture_lat_addr", lat_addr, 2);
        tick(1);
        req = 4'b0000;
        tick(1);
        chk("capture_busy", busy, 0);
        tick(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
